uart_recv: RTL and testbench

//  UART receiver, 8N1, LSB first; counterpart of the uart_send transmitter on the same serial link.

---
 rtl/uart_recv.sv | 117 +++++++++++
 tb/tb_uart_recv.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_recv.sv
// 8N1 UART receiver, LSB first, mid-bit sampling with a 2-flop input synchroniser.
// Define UART_RECV_MAJORITY_EN to take each sample as a 3-cycle majority vote of rx_s.
module uart_recv #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int          HALF    = CLKS_PER_BIT / 2;
  localparam logic [15:0] HALF_TC = 16'(HALF - 1);
  localparam logic [15:0] BIT_TC  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_n;
  logic        s1, rx_s, sample;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shift_reg, shift_n, data_n;
  logic        valid_n, ferr_n;

`ifdef UART_RECV_MAJORITY_EN
  // Two previous rx_s values; with the current rx_s they form the 3-deep history.
  logic [1:0] hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist <= '1;
    else     hist <= {hist[0], rx_s};
  end

  assign sample = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
`else
  assign sample = rx_s;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 16'd1;
    bit_idx_n = bit_idx;
    shift_n   = shift_reg;
    data_n    = data;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF_TC) begin
          cnt_n = '0;
          if (!sample) begin
            state_n   = DATA;
            bit_idx_n = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt == BIT_TC) begin
          cnt_n     = '0;
          shift_n   = {sample, shift_reg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        // Leave at mid-stop-bit so a back-to-back start edge is not missed.
        if (cnt == BIT_TC) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (sample) begin
            data_n  = shift_reg;
            valid_n = 1'b1;
          end else begin
            ferr_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1        <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      s1        <= din;
      rx_s      <= s1;
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shift_reg <= shift_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
    end
  end

endmodule

// File: tb/tb_uart_recv.sv
// Self-checking bench for uart_recv: directed frames plus random frames against an event scoreboard.
module tb_uart_recv;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  // din falls after edge k -> valid/frame_err high after edge k+3+HALF+9*CPB.
  localparam int LAT  = 3 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, busy;

  uart_recv #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .din(din),
    .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          ok;
    logic [7:0]  d;
    int unsigned c;
  } ev_t;

  ev_t        got_q[$];
  ev_t        exp_q[$];
  logic [7:0] model_data = 8'h00;
  bit         both_seen  = 1'b0;
  int         errors = 0;
  int         checks = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (valid)     got_q.push_back('{1'b1, data, cyc});
      if (frame_err) got_q.push_back('{1'b0, data, cyc});
      if (valid && frame_err) both_seen = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; glitch_bit (0..7) puts a 1-cycle high pulse on that bit's sample point.
  task automatic send(input logic [7:0] b, input bit stop, input int glitch_bit,
                      input logic [7:0] expect_b);
    int unsigned fc;
    fc  = cyc;
    din = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      din = b[i];
      if (i == glitch_bit) begin
        tick(HALF);
        din = 1'b1;
        tick(1);
        din = b[i];
        tick(CPB - HALF - 1);
      end else begin
        tick(CPB);
      end
    end
    din = stop;
    tick(CPB);
    din = 1'b1;
    if (stop) begin
      model_data = expect_b;
      exp_q.push_back('{1'b1, expect_b, fc + LAT});
    end else begin
      exp_q.push_back('{1'b0, model_data, fc + LAT});
    end
  endtask

  task automatic compare_events(input string tag);
    ev_t g, e;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_kind"}, {31'd0, g.ok}, {31'd0, e.ok});
      check({tag, "_data"}, {24'd0, g.d}, {24'd0, e.d});
      check({tag, "_cycle"}, g.c, e.c);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] rb;
    bit         rs;

    // Reset state
    tick(3);
    check("rst_data", {24'd0, data}, 32'h0);
    check("rst_valid", {31'd0, valid}, 32'h0);
    check("rst_ferr", {31'd0, frame_err}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    rst = 1'b0;
    tick(5);

    // Single good frame
    send(8'hA5, 1'b1, -1, 8'hA5);
    tick(20);
    compare_events("a5");
    check("a5_busy_after", {31'd0, busy}, 32'h0);
    check("a5_data_hold", {24'd0, data}, 32'hA5);

    // Back-to-back frames, no idle gap
    send(8'h00, 1'b1, -1, 8'h00);
    send(8'hFF, 1'b1, -1, 8'hFF);
    tick(20);
    compare_events("b2b");

    // Short low pulse is a false start
    din = 1'b0;
    tick(3);
    din = 1'b1;
    tick(1);
    check("glitch_busy_high", {31'd0, busy}, 32'h1);
    tick(20);
    check("glitch_busy_low", {31'd0, busy}, 32'h0);
    compare_events("false_start");

    // Bad stop bit
    send(8'h3C, 1'b0, -1, 8'h3C);
    tick(20);
    compare_events("stop0");
    check("stop0_data_hold", {24'd0, data}, 32'hFF);

    // Reset in the middle of bit 4
    din = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      din = i[0];
      tick(CPB);
    end
    din = 1'b1;
    tick(HALF);
    rst = 1'b1;
    tick(3);
    check("midrst_busy", {31'd0, busy}, 32'h0);
    check("midrst_data", {24'd0, data}, 32'h0);
    model_data = 8'h00;
    rst = 1'b0;
    tick(CPB * 8);
    compare_events("aborted");
    send(8'h5A, 1'b1, -1, 8'h5A);
    tick(20);
    compare_events("after_rst");

    // One-cycle glitch on the bit-2 sample point of 0x00
`ifdef UART_RECV_MAJORITY_EN
    send(8'h00, 1'b1, 2, 8'h00);
`else
    send(8'h00, 1'b1, 2, 8'h04);
`endif
    tick(20);
    compare_events("sample_glitch");

    // Random frames, random stop bits and gaps
    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(3, 0) != 0);
      send(rb, rs, -1, rb);
      if (!rs) tick(20 + $urandom_range(5, 0));
      else     tick($urandom_range(3, 0));
    end
    tick(20);
    compare_events("random");

    check("never_both", {31'd0, both_seen}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
